// File: rtl/adj_key_ctrl.sv
// Adjust-key front end: synchronizes, debounces and pulses the hour/minute keys.
// Build with AUTO_REPEAT_EN defined to get hold-to-repeat pulses.
module adj_key_ctrl #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int RATE_CYCLES = 5_000_000
) (
  input  logic CP50,
  input  logic nCR,
  input  logic KeyH_n,
  input  logic KeyM_n,
  output logic IncH,
  output logic IncM,
  output logic HeldH,
  output logic HeldM
);
  // state      | meaning
  // IDLE       | key released, waiting for a pressed sync level
  // PRESS_DB   | pressed level seen, counting stable pressed cycles
  // HELD       | press accepted, Held high, repeat timer running
  // RELEASE_DB | released level seen, counting stable released cycles

  localparam int MAX_CYCLES = (DB_CYCLES > HOLD_CYCLES)
                            ? ((DB_CYCLES > RATE_CYCLES) ? DB_CYCLES : RATE_CYCLES)
                            : ((HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES);
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] DB_TC = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  logic [1:0] key_n;
  logic [1:0] inc;
  logic [1:0] held;

  assign key_n = {KeyM_n, KeyH_n};
  assign IncH  = inc[0];
  assign IncM  = inc[1];
  assign HeldH = held[0];
  assign HeldM = held[1];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_t        state_q, state_d;
    logic          sync1, sync2;
    logic          pressed;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          inc_q, inc_d;
    logic          held_q, held_d;

    // Synchronizer resets to the released level so a held key looks like a fresh press.
    always_ff @(posedge CP50 or negedge nCR) begin
      if (!nCR) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= key_n[c];
        sync2 <= sync1;
      end
    end

    assign pressed = ~sync2;

`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RATE_TC = CW'(RATE_CYCLES - 1);

    logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [CW-1:0] rpt_tc;
    logic          hold_tgt_q, hold_tgt_d;

    always_ff @(posedge CP50 or negedge nCR) begin
      if (!nCR) begin
        rpt_cnt_q  <= '0;
        hold_tgt_q <= 1'b1;
      end else begin
        rpt_cnt_q  <= rpt_cnt_d;
        hold_tgt_q <= hold_tgt_d;
      end
    end

    assign rpt_tc = hold_tgt_q ? HOLD_TC : RATE_TC;
`endif

    always_ff @(posedge CP50 or negedge nCR) begin
      if (!nCR) begin
        state_q  <= IDLE;
        db_cnt_q <= '0;
        inc_q    <= 1'b0;
        held_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        db_cnt_q <= db_cnt_d;
        inc_q    <= inc_d;
        held_q   <= held_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      db_cnt_d = db_cnt_q;
      inc_d    = 1'b0;
      held_d   = held_q;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_d  = rpt_cnt_q;
      hold_tgt_d = hold_tgt_q;
`endif
      case (state_q)
        IDLE: begin
          held_d = 1'b0;
          if (pressed) begin
            state_d  = PRESS_DB;
            db_cnt_d = '0;
          end
        end
        PRESS_DB: begin
          if (!pressed) begin
            state_d  = IDLE;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_TC) begin
            state_d  = HELD;
            db_cnt_d = '0;
            inc_d    = 1'b1;
            held_d   = 1'b1;
`ifdef AUTO_REPEAT_EN
            rpt_cnt_d  = '0;
            hold_tgt_d = 1'b1;
`endif
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        HELD: begin
          // Release wins over a coincident repeat expiry.
          if (!pressed) begin
            state_d  = RELEASE_DB;
            db_cnt_d = '0;
          end
`ifdef AUTO_REPEAT_EN
          else if (rpt_cnt_q == rpt_tc) begin
            inc_d      = 1'b1;
            rpt_cnt_d  = '0;
            hold_tgt_d = 1'b0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
`endif
        end
        RELEASE_DB: begin
          if (pressed) begin
            state_d  = HELD;
            db_cnt_d = '0;
`ifdef AUTO_REPEAT_EN
            rpt_cnt_d = '0;
`endif
          end else if (db_cnt_q == DB_TC) begin
            state_d  = IDLE;
            db_cnt_d = '0;
            held_d   = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          db_cnt_d = '0;
          held_d   = 1'b0;
        end
      endcase
    end

    assign inc[c]  = inc_q;
    assign held[c] = held_q;
  end

endmodule

// File: tb/tb_adj_key_ctrl.sv
// Bench for adj_key_ctrl: directed key scenarios plus random bouncing keys,
// checked cycle by cycle against an event-level debounce/repeat model.
module tb_adj_key_ctrl;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int RATE = 8;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic CP50 = 1'b0;
  logic nCR, KeyH_n, KeyM_n;
  logic IncH, IncM, HeldH, HeldM;

  adj_key_ctrl #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RATE_CYCLES(RATE)) dut (
    .CP50(CP50), .nCR(nCR), .KeyH_n(KeyH_n), .KeyM_n(KeyM_n),
    .IncH(IncH), .IncM(IncM), .HeldH(HeldH), .HeldM(HeldM)
  );

  always #5 CP50 = ~CP50;

  int total = 0;
  int bad   = 0;
  int gk    = 0;
  int sc    = 0;
  int qh[$];
  int qm[$];
  int fall_h, fall_m;
  logic prev_hh, prev_hm;

  // Model state: accepted level, run of cycles disagreeing with it, next repeat time.
  bit acc[2];
  int run_len[2];
  int next_fire[2];
  int pend[2];
  bit dly1[2];
  bit dly2[2];
  bit exp_inc[2];

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (sc=%0d)", tag, got, want, sc);
    end
  endtask

  task automatic chk_list(input string tag, input int got[$], input int want[$]);
    chk({tag, "_count"}, got.size(), want.size());
    foreach (want[i]) chk(tag, (i < got.size()) ? got[i] : -1, want[i]);
  endtask

  task automatic model_edge(input int c, input bit p, input bit rn);
    bit lvl;
    exp_inc[c] = 1'b0;
    if (!rn) begin
      acc[c] = 1'b0; run_len[c] = 0; dly1[c] = 1'b0; dly2[c] = 1'b0;
      return;
    end
    lvl = dly2[c];
    if (lvl != acc[c]) run_len[c]++;
    else begin
      if (acc[c] && run_len[c] > 0) next_fire[c] = gk + pend[c];
      run_len[c] = 0;
    end
    if (run_len[c] == DB + 1) begin
      acc[c] = lvl;
      run_len[c] = 0;
      if (lvl) begin
        exp_inc[c] = 1'b1;
        next_fire[c] = gk + HOLD;
        pend[c] = HOLD;
      end
    end else if (AUTO && acc[c] && lvl && gk == next_fire[c]) begin
      exp_inc[c] = 1'b1;
      pend[c] = RATE;
      next_fire[c] = gk + RATE;
    end
    dly2[c] = dly1[c];
    dly1[c] = p;
  endtask

  task automatic step(input bit kh, input bit km, input bit rn);
    bit was_rst;
    was_rst = (nCR == 1'b0);
    KeyH_n = kh; KeyM_n = km; nCR = rn;
    if (!rn && !was_rst) begin
      #1;
      chk("rst_imm_inch", int'(IncH), 0);
      chk("rst_imm_heldh", int'(HeldH), 0);
    end
    @(posedge CP50);
    gk++; sc++;
    #1;
    model_edge(0, !kh, rn);
    model_edge(1, !km, rn);
    chk("inc_h", int'(IncH), int'(exp_inc[0]));
    chk("inc_m", int'(IncM), int'(exp_inc[1]));
    chk("held_h", int'(HeldH), int'(acc[0]));
    chk("held_m", int'(HeldM), int'(acc[1]));
    if (IncH) qh.push_back(sc);
    if (IncM) qm.push_back(sc);
    if (prev_hh && !HeldH && fall_h < 0) fall_h = sc;
    if (prev_hm && !HeldM && fall_m < 0) fall_m = sc;
    prev_hh = HeldH;
    prev_hm = HeldM;
  endtask

  task automatic sc_start();
    sc = -1;
    qh.delete(); qm.delete();
    fall_h = -1; fall_m = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    int e[$];
    int rem[2];
    bit lv[2];
    bit rn;
    nCR = 1'b0; KeyH_n = 1'b1; KeyM_n = 1'b1;
    prev_hh = 1'b0; prev_hm = 1'b0;
    for (int c = 0; c < 2; c++) begin
      acc[c] = 0; run_len[c] = 0; next_fire[c] = 0; pend[c] = HOLD;
      dly1[c] = 0; dly2[c] = 0; exp_inc[c] = 0;
    end
    #2;
    chk("reset_inch", int'(IncH), 0);
    chk("reset_incm", int'(IncM), 0);
    chk("reset_heldh", int'(HeldH), 0);
    chk("reset_heldm", int'(HeldM), 0);
    @(posedge CP50); #1;
    step(1'b1, 1'b1, 1'b0);
    idle(5);

    // single press, short hold
    sc_start();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    idle(12);
    e = '{6};
    chk_list("s1_inch", qh, e);
    e = '{};
    chk_list("s1_incm", qm, e);
    chk("s1_heldh_fall", fall_h, 16);

    // bounce then real press
    sc_start();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    idle(12);
    e = '{10};
    chk_list("s2_inch", qh, e);

    // long minute hold with auto-repeat
    sc_start();
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b1);
    idle(12);
    if (AUTO) e = '{6, 26, 34, 42, 50, 58};
    else      e = '{6};
    chk_list("s3_incm", qm, e);
    chk("s3_heldm_fall", fall_m, 66);

    // both keys together
    sc_start();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    idle(12);
    e = '{6};
    chk_list("s4_inch", qh, e);
    chk_list("s4_incm", qm, e);

    // reset while held
    sc_start();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b1);
    idle(12);
    if (AUTO) e = '{6, 26, 39};
    else      e = '{6, 39};
    chk_list("s5_inch", qh, e);
    chk("s5_heldh_fall", fall_h, 30);

    // release glitch during hold
    sc_start();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b1);
    idle(12);
    if (AUTO) e = '{6, 26, 34, 52, 60};
    else      e = '{6};
    chk_list("s6_inch", qh, e);
    chk("s6_heldh_fall", fall_h, 66);

    // random bouncing keys with occasional resets
    rem[0] = 0; rem[1] = 0; lv[0] = 0; lv[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          lv[c] = !lv[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 45);
        end
        rem[c]--;
      end
      rn = ($urandom_range(0, 499) != 0);
      step(!lv[0], !lv[1], rn);
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
